memory_test_hw_nios2_cpu_debug_ocimem_ctrl: RTL and testbench

System-clock consumer of the debug slave's decoded JTAG commands. It takes the `take_*_ocimem_*` strobes and the 38-bit `jdo` payload and runs word reads and writes against the on-chip debug monitor RAM. It maintains an auto-incrementing monitor address and returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave for shift-out over JTAG.

---
 rtl/memory_test_hw_nios2_ocimem_pkg.sv | 17 +
 rtl/memory_test_hw_nios2_cpu_debug_ocimem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_memory_test_hw_nios2_cpu_debug_ocimem_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_test_hw_nios2_ocimem_pkg.sv
// Shared definitions for the OCI debug-memory controller: where each field
// sits in the 38-bit jdo payload, and the controller state encoding.
package memory_test_hw_nios2_ocimem_pkg;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;  // address field is jdo[AW+16:17]
    localparam int JDO_DATA_MSB  = 34;  // write data is jdo[34:3]
    localparam int JDO_DATA_LSB  = 3;
    localparam int JDO_RDFLAG    = 34;  // read-after-load flag (address load only)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/memory_test_hw_nios2_cpu_debug_ocimem_ctrl.sv
// System-clock side of the JTAG debug-memory path. Decoded take_* strobes
// drive single-word reads and writes of the debug monitor RAM through an
// auto-incrementing monitor address; results go back via MonDReg,
// monitor_ready and a sticky monitor_error.
//
// Handshake: a strobe is a one-cycle request that is honoured only while the
// FSM is IDLE. There is no back-pressure; a strobe that is not honoured
// (busy, or lost arbitration) is dropped and recorded in monitor_error.
// monitor_ready high means the previous command has completed.
module memory_test_hw_nios2_cpu_debug_ocimem_ctrl
    import memory_test_hw_nios2_ocimem_pkg::*;
#(
    parameter int AW         = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [AW-1:0]     MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output state_t            dbg_state
);

    // Counter value at which read data is on ram_rdata (first RD_WAIT cycle is 0).
    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY);

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic            ram_rd_q, ram_rd_d;
    logic            ram_wr_q, ram_wr_d;
    logic [31:0]     ram_wdata_q, ram_wdata_d;
    logic [AW-1:0]   mon_a_q, mon_a_d;
    logic [31:0]     mon_d_q, mon_d_d;
    logic            ready_q, ready_d;
    logic            error_q, error_d;

    logic [AW-1:0]   jdo_addr;
    logic [31:0]     jdo_data;
    logic            jdo_rdflag;
    logic            any_strobe;
    logic            unused_jdo_bits;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: AW];
    assign jdo_data   = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    assign jdo_rdflag = jdo[JDO_RDFLAG];
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0]};

    // Command arbitration, RAM pulse generation and read-latency tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        mon_a_d     = mon_a_q;
        mon_d_d     = mon_d_q;
        ready_d     = ready_q;
        error_d     = error_q;

        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    // Address load wins; a simultaneous lower strobe still flags.
                    mon_a_d = jdo_addr;
                    error_d = take_action_ocimem_b | take_no_action_ocimem_a;
                    if (jdo_rdflag) begin
                        ram_rd_d   = 1'b1;
                        ram_addr_d = jdo_addr;
                        ready_d    = 1'b0;
                        cnt_d      = 2'd0;
                        state_d    = RD_WAIT;
                    end
                end else if (take_action_ocimem_b) begin
                    ram_wr_d    = 1'b1;
                    ram_addr_d  = mon_a_q;
                    ram_wdata_d = jdo_data;
                    mon_d_d     = jdo_data;
                    mon_a_d     = mon_a_q + 1'b1;
                    ready_d     = 1'b0;
                    state_d     = WR_DONE;
                    if (take_no_action_ocimem_a) begin
                        error_d = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    ram_rd_d   = 1'b1;
                    ram_addr_d = mon_a_q;
                    mon_a_d    = mon_a_q + 1'b1;
                    ready_d    = 1'b0;
                    cnt_d      = 2'd0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                if (cnt_q == LAT_LAST) begin
                    mon_d_d = ram_rdata;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WR_DONE: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_wdata_q <= '0;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            ready_q     <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            ram_wdata_q <= ram_wdata_d;
            mon_a_q     <= mon_a_d;
            mon_d_q     <= mon_d_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_rd        = ram_rd_q;
    assign ram_wr        = ram_wr_q;
    assign ram_wdata     = ram_wdata_q;
    assign MonAReg       = mon_a_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_memory_test_hw_nios2_cpu_debug_ocimem_ctrl.sv
// Bench for the OCI debug-memory controller. Two instances share the same
// strobes: u1 with a 1-cycle RAM, u2 with a 2-cycle RAM. Each has its own RAM
// model that only presents valid data in the correct cycle.
module tb_memory_test_hw_nios2_cpu_debug_ocimem_ctrl;
    import memory_test_hw_nios2_ocimem_pkg::*;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        st_a, st_b, st_n;

    logic [AW-1:0] r1_addr, r2_addr, a1_reg, a2_reg;
    logic          r1_rd, r2_rd, r1_wr, r2_wr;
    logic [31:0]   r1_wdata, r2_wdata, r1_rdata, r2_rdata, d1_reg, d2_reg;
    logic          rdy1, rdy2, err1, err2;
    state_t        st1, st2;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   exp1_q[$];
    logic [31:0]   exp2_q[$];

    always #5 clk = ~clk;

    memory_test_hw_nios2_cpu_debug_ocimem_ctrl #(.AW(AW), .RD_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(st_a), .take_action_ocimem_b(st_b),
        .take_no_action_ocimem_a(st_n),
        .ram_addr(r1_addr), .ram_rd(r1_rd), .ram_wr(r1_wr), .ram_wdata(r1_wdata),
        .ram_rdata(r1_rdata), .MonAReg(a1_reg), .MonDReg(d1_reg),
        .monitor_ready(rdy1), .monitor_error(err1), .dbg_state(st1)
    );

    memory_test_hw_nios2_cpu_debug_ocimem_ctrl #(.AW(AW), .RD_LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(st_a), .take_action_ocimem_b(st_b),
        .take_no_action_ocimem_a(st_n),
        .ram_addr(r2_addr), .ram_rd(r2_rd), .ram_wr(r2_wr), .ram_wdata(r2_wdata),
        .ram_rdata(r2_rdata), .MonAReg(a2_reg), .MonDReg(d2_reg),
        .monitor_ready(rdy2), .monitor_error(err2), .dbg_state(st2)
    );

    // Fixed RAM contents; 0x20 holds the well-known test word.
    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a == 8'h20) return 32'hDEADBEEF;
        return {8'h5A, a, ~a, 8'h3C ^ a};
    endfunction

    // RAM models: garbage unless the read issued the right number of cycles ago.
    logic [31:0] p1, p2a, p2b;
    always @(posedge clk) begin
        p1  <= r1_rd ? init_word(r1_addr) : 32'h0BAD0BAD;
        p2a <= r2_rd ? init_word(r2_addr) : 32'h0BAD0BAD;
        p2b <= p2a;
    end
    assign r1_rdata = p1;
    assign r2_rdata = p2b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop1(input string tag);
        if (exp1_q.size() == 0) chk({tag, "_q1empty"}, 32'd0, 32'd1);
        else chk(tag, d1_reg, exp1_q.pop_front());
    endtask

    task automatic chk_pop2(input string tag);
        if (exp2_q.size() == 0) chk({tag, "_q2empty"}, 32'd0, 32'd1);
        else chk(tag, d2_reg, exp2_q.pop_front());
    endtask

    // Drive one strobe cycle; returns one cycle after the accepting edge.
    task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
        st_a = a; st_b = b; st_n = n; jdo = j;
        step();
        st_a = 1'b0; st_b = 1'b0; st_n = 1'b0; jdo = '0;
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic flag);
        logic [37:0] j;
        j = '0;
        j[JDO_ADDR_LSB +: AW] = addr;
        j[JDO_RDFLAG] = flag;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[JDO_DATA_MSB:JDO_DATA_LSB] = data;
        return j;
    endfunction

    // Wait until both instances report ready, with a cycle budget.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!(rdy1 && rdy2) && cyc < 20) begin
            step();
            cyc++;
        end
        chk("ready_timeout", 32'(cyc < 20), 32'd1);
    endtask

    initial begin
        int cyc;
        logic [7:0] ra;
        reset = 1'b1; st_a = 1'b0; st_b = 1'b0; st_n = 1'b0; jdo = '0;
        #1;
        // Reset values
        chk("rst_mona", 32'(a1_reg), 32'h0);
        chk("rst_mond", d1_reg, 32'h0);
        chk("rst_ready", {30'd0, rdy1, rdy2}, 32'h3);
        chk("rst_err_rd_wr", {28'd0, err1, err2, r1_rd, r1_wr}, 32'h0);
        chk("rst_state", 32'(st2), 32'(IDLE));
        step(); step();
        reset = 1'b0;
        step();

        // Address load, no read
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b0));
        chk("ld_mona", 32'(a1_reg), 32'h10);
        chk("ld_no_rd", {30'd0, r1_rd, r2_rd}, 32'h0);
        chk("ld_ready", {30'd0, rdy1, rdy2}, 32'h3);
        chk("ld_state", 32'(st1), 32'(IDLE));

        // Address load with read, exact timing for latency 1
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'h20, 1'b1));
        exp1_q.push_back(32'hDEADBEEF);
        exp2_q.push_back(32'hDEADBEEF);
        chk("ldrd_rd", {30'd0, r1_rd, r2_rd}, 32'h3);
        chk("ldrd_addr", 32'(r1_addr), 32'h20);
        chk("ldrd_notready", {30'd0, rdy1, rdy2}, 32'h0);
        step();                                   // N+2
        chk("ldrd_rd_1cyc", {30'd0, r1_rd, r2_rd}, 32'h0);
        chk("ldrd_n2_notready", 32'(rdy1), 32'd0);
        step();                                   // N+3
        chk("ldrd_n3_ready1", 32'(rdy1), 32'd1);
        chk_pop1("ldrd_mond1");
        chk("ldrd_n3_notready2", 32'(rdy2), 32'd0);
        chk("ldrd_mona", 32'(a1_reg), 32'h20);
        step();                                   // N+4
        chk("ldrd_n4_ready2", 32'(rdy2), 32'd1);
        chk_pop2("ldrd_mond2");

        // Write at top address, address wraps
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'hFF, 1'b0));
        pulse(1'b0, 1'b1, 1'b0, mk_b(32'h12345678));
        chk("wr_pulse", {30'd0, r1_wr, r2_wr}, 32'h3);
        chk("wr_addr", 32'(r1_addr), 32'hFF);
        chk("wr_wdata", r2_wdata, 32'h12345678);
        chk("wr_mond", d1_reg, 32'h12345678);
        chk("wr_wrap", 32'(a2_reg), 32'h00);
        chk("wr_notready", {30'd0, rdy1, rdy2}, 32'h0);
        step();                                   // N+2
        chk("wr_ready", {30'd0, rdy1, rdy2}, 32'h3);
        chk("wr_1cyc", {30'd0, r1_wr, r2_wr}, 32'h0);

        // Three read-next commands from 0x05
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'h05, 1'b0));
        for (int i = 0; i < 3; i++) begin
            ra = 8'h05 + 8'(i);
            pulse(1'b0, 1'b0, 1'b1, '0);
            exp1_q.push_back(init_word(ra));
            exp2_q.push_back(init_word(ra));
            chk($sformatf("rn%0d_addr", i), {16'd0, r1_addr, r2_addr}, {16'd0, ra, ra});
            chk($sformatf("rn%0d_rd", i), {30'd0, r1_rd, r2_rd}, 32'h3);
            wait_ready(cyc);
            chk($sformatf("rn%0d_lat2", i), 32'(cyc), 32'd3);
            chk_pop1($sformatf("rn%0d_mond1", i));
            chk_pop2($sformatf("rn%0d_mond2", i));
        end
        chk("rn_mona", {16'd0, a1_reg, a2_reg}, 32'h0808);

        // Write and read-next together: write wins, error sets
        pulse(1'b0, 1'b1, 1'b1, mk_b(32'hCAFEF00D));
        chk("arb_wr", {29'd0, r1_wr, r1_rd, r2_rd}, 32'h4);
        chk("arb_addr", 32'(r2_addr), 32'h08);
        chk("arb_err", {30'd0, err1, err2}, 32'h3);
        chk("arb_mona", 32'(a1_reg), 32'h09);
        step();
        // Read-next, then a strobe while the read is pending
        pulse(1'b0, 1'b0, 1'b1, '0);
        exp1_q.push_back(init_word(8'h09));
        exp2_q.push_back(init_word(8'h09));
        pulse(1'b0, 1'b1, 1'b0, mk_b(32'h11111111));
        chk("busy_no_wr", {30'd0, r1_wr, r2_wr}, 32'h0);
        wait_ready(cyc);
        chk_pop1("busy_mond1");
        chk_pop2("busy_mond2");
        chk("busy_mona", 32'(a2_reg), 32'h0A);
        chk("err_sticky", {30'd0, err1, err2}, 32'h3);
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'h40, 1'b0));
        chk("err_clear", {30'd0, err1, err2}, 32'h0);

        // Reset during RD_WAIT
        pulse(1'b0, 1'b0, 1'b1, '0);
        chk("rstrd_state", 32'(st1), 32'(RD_WAIT));
        reset = 1'b1;
        #1;
        chk("rstrd_mond", d1_reg, 32'h0);
        chk("rstrd_ready", {30'd0, rdy1, rdy2}, 32'h3);
        chk("rstrd_state_idle", {30'd0, st2}, 32'(IDLE));
        chk("rstrd_mona", 32'(a2_reg), 32'h0);
        step(); step();
        reset = 1'b0;
        step();
        chk("rstrd_mond_held", {d1_reg ^ d2_reg}, 32'h0);
        pulse(1'b0, 1'b0, 1'b1, '0);
        exp1_q.push_back(init_word(8'h00));
        exp2_q.push_back(init_word(8'h00));
        chk("post_rst_addr", {16'd0, r1_addr, r2_addr}, 32'h0);
        chk("post_rst_rd", {30'd0, r1_rd, r2_rd}, 32'h3);
        wait_ready(cyc);
        chk_pop1("post_rst_mond1");
        chk_pop2("post_rst_mond2");
        chk("q_drained", 32'(exp1_q.size() + exp2_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
